toeplitz_seed_loader: RTL and testbench

- Runtime-loadable successor to the static file-initialised Toeplitz seed source.
- Accepts BS-bit seed words over a valid/ready stream, first the column words and then the reversed-row words, and assembles them in a shadow buffer.
- Commits the shadow buffer atomically to the `rrow0`/`col0` outputs that feed the Toeplitz hash core. The core can defer a commit while it is mid-block.

---
 rtl/toeplitz_pkg.sv | 9 +
 rtl/seed_shadow_buf.sv | 35 +++
 rtl/toeplitz_seed_loader.sv | 116 +++++++++++
 tb/tb_toeplitz_seed_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/toeplitz_pkg.sv
// toeplitz_pkg: shared state encoding, default seed geometry and seed file names for the Toeplitz seed loader.
package toeplitz_pkg;
    typedef enum logic [1:0] {IDLE, LOAD_COL, LOAD_ROW, COMMIT} seed_state_t;
    localparam int DEF_BS = 64;
    localparam int DEF_N  = 256;
    localparam int DEF_L  = 128;
    localparam string C_FILE  = "c64-hex.dat";
    localparam string RR_FILE = "rr64-hex.dat";
endpackage

// File: rtl/seed_shadow_buf.sv
// seed_shadow_buf: shadow column/reversed-row word arrays with indexed writes and flattened views (word 0 in the MSBs).
module seed_shadow_buf #(
    parameter int BS  = 64,
    parameter int XSZ = 4,
    parameter int YSZ = 2,
    parameter int CW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_col_i,
    input  logic              wr_row_i,
    input  logic [CW-1:0]     idx_i,
    input  logic [BS-1:0]     data_i,
    output logic [YSZ*BS-1:0] col_o,
    output logic [XSZ*BS-1:0] row_o
);
    logic [BS-1:0] c_q  [YSZ];
    logic [BS-1:0] rr_q [XSZ];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < YSZ; i++) c_q[i] <= '0;
            for (int i = 0; i < XSZ; i++) rr_q[i] <= '0;
        end else begin
            for (int i = 0; i < YSZ; i++) if (wr_col_i && idx_i == CW'(i)) c_q[i] <= data_i;
            for (int i = 0; i < XSZ; i++) if (wr_row_i && idx_i == CW'(i)) rr_q[i] <= data_i;
        end

    for (genvar g = 0; g < YSZ; g++) begin : g_col
        assign col_o[(YSZ-1-g)*BS +: BS] = c_q[g];
    end
    for (genvar g = 0; g < XSZ; g++) begin : g_row
        assign row_o[(XSZ-1-g)*BS +: BS] = rr_q[g];
    end
endmodule

// File: rtl/toeplitz_seed_loader.sv
// toeplitz_seed_loader: streams seed words into a shadow buffer and commits them atomically to rrow0/col0.
module toeplitz_seed_loader
    import toeplitz_pkg::*;
#(
    parameter int BS = DEF_BS,
    parameter int N  = DEF_N,
    parameter int L  = DEF_L,
    parameter logic [L-1:0] PRE_COL = '0,
    parameter logic [N-1:0] PRE_ROW = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          abort,
    input  logic [BS-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          hold,
    output logic [N-1:0]  rrow0,
    output logic [L-1:0]  col0,
    output logic          seed_ok,
    output logic          seed_update,
    output logic          busy
);
    localparam int XSZ = N / BS;
    localparam int YSZ = L / BS;
    localparam int CW  = $clog2((XSZ > YSZ ? XSZ : YSZ) + 1);

`ifdef SEED_PRELOAD_EN
    localparam logic [L-1:0] COL_RST = PRE_COL;
    localparam logic [N-1:0] ROW_RST = PRE_ROW >> 1;
    localparam logic         OK_RST  = 1'b1;
`else
    localparam logic [L-1:0] COL_RST = '0;
    localparam logic [N-1:0] ROW_RST = '0;
    localparam logic         OK_RST  = 1'b0;
`endif

    seed_state_t   st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [L-1:0]  col0_q, col_flat;
    logic [N-1:0]  rrow0_q, row_flat;
    logic          ok_q, upd_q;
    logic          xfer, wr_col, wr_row, commit;

    assign s_ready     = st_q == LOAD_COL || st_q == LOAD_ROW;
    assign busy        = st_q != IDLE;
    assign xfer        = s_valid & s_ready;
    assign col0        = col0_q;
    assign rrow0       = rrow0_q;
    assign seed_ok     = ok_q;
    assign seed_update = upd_q;

    // abort takes priority over any transfer or commit on the same edge
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        wr_col = 1'b0;
        wr_row = 1'b0;
        commit = 1'b0;
        case (st_q)
            IDLE: if (load_start) begin
                st_d  = LOAD_COL;
                cnt_d = '0;
            end
            LOAD_COL: if (abort) st_d = IDLE;
            else if (xfer) begin
                wr_col = 1'b1;
                st_d   = cnt_q == CW'(YSZ-1) ? LOAD_ROW : LOAD_COL;
                cnt_d  = cnt_q == CW'(YSZ-1) ? '0 : cnt_q + CW'(1);
            end
            LOAD_ROW: if (abort) st_d = IDLE;
            else if (xfer) begin
                wr_row = 1'b1;
                st_d   = cnt_q == CW'(XSZ-1) ? COMMIT : LOAD_ROW;
                cnt_d  = cnt_q == CW'(XSZ-1) ? '0 : cnt_q + CW'(1);
            end
            COMMIT: if (abort) st_d = IDLE;
            else if (!hold) begin
                commit = 1'b1;
                st_d   = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st_q    <= IDLE;
            cnt_q   <= '0;
            col0_q  <= COL_RST;
            rrow0_q <= ROW_RST;
            ok_q    <= OK_RST;
            upd_q   <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            upd_q <= commit;
            if (commit) begin
                col0_q  <= col_flat;
                rrow0_q <= row_flat >> 1;
                ok_q    <= 1'b1;
            end
        end

    seed_shadow_buf #(.BS(BS), .XSZ(XSZ), .YSZ(YSZ), .CW(CW)) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .wr_col_i (wr_col),
        .wr_row_i (wr_row),
        .idx_i    (cnt_q),
        .data_i   (s_data),
        .col_o    (col_flat),
        .row_o    (row_flat)
    );
endmodule

// File: tb/tb_toeplitz_seed_loader.sv
// tb_toeplitz_seed_loader: directed vectors and hand-written sequences for the default build (BS=64, N=256, L=128).
module tb_toeplitz_seed_loader;
    logic          clk = 1'b0, rst = 1'b1;
    logic          load_start = 1'b0, abort = 1'b0, s_valid = 1'b0, hold = 1'b0;
    logic [63:0]   s_data = '0;
    logic          s_ready, seed_ok, seed_update, busy;
    logic [255:0]  rrow0;
    logic [127:0]  col0;
    int            n_cmp = 0, n_err = 0;

    typedef struct {
        logic         ld, ab, v, h;
        logic [63:0]  d;
        logic         rdy, bsy, upd, ok;
        logic [127:0] col;
        logic [255:0] row;
    } vec_t;
    vec_t vt [9];

    localparam logic [63:0]  W1  = 64'h1111111111111111;
    localparam logic [63:0]  W2  = 64'h2222222222222222;
    localparam logic [63:0]  WR0 = 64'h8000000000000000;
    localparam logic [63:0]  WR3 = 64'h0000000000000003;
    localparam logic [127:0] EC1 = {W1, W2};
    localparam logic [255:0] ER1 = {64'h4000000000000000, 64'h0, 64'h0, 64'h0000000000000001};

    always #5 clk = ~clk;

    toeplitz_seed_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .abort       (abort),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .hold        (hold),
        .rrow0       (rrow0),
        .col0        (col0),
        .seed_ok     (seed_ok),
        .seed_update (seed_update),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [127:0] c, input logic [255:0] r);
        chk({nm, ".col0"}, col0, c);
        chk({nm, ".rrow0"}, rrow0, r);
    endtask

    function automatic logic [255:0] rowx(input logic [63:0] a, b, c, d);
        return {a, b, c, d} >> 1;
    endfunction

    initial begin
        logic [127:0] pc;
        logic [255:0] pr;
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 128'h0, 256'h0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, W1,    1'b1, 1'b1, 1'b0, 1'b0, 128'h0, 256'h0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, W2,    1'b1, 1'b1, 1'b0, 1'b0, 128'h0, 256'h0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, WR0,   1'b1, 1'b1, 1'b0, 1'b0, 128'h0, 256'h0};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 128'h0, 256'h0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 128'h0, 256'h0};
        vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, WR3,   1'b0, 1'b1, 1'b0, 1'b0, 128'h0, 256'h0};
        vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1, EC1,    ER1};
        vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, EC1,    ER1};

        tick();
        tick();
        chk("rst.col0", col0, '0);
        chk("rst.rrow0", rrow0, '0);
        chk("rst.seed_ok", seed_ok, 1'b0);
        chk("rst.s_ready", s_ready, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.seed_update", seed_update, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            load_start = vt[i].ld;
            abort      = vt[i].ab;
            s_valid    = vt[i].v;
            hold       = vt[i].h;
            s_data     = vt[i].d;
            tick();
            chk($sformatf("v%0d.s_ready", i), s_ready, vt[i].rdy);
            chk($sformatf("v%0d.busy", i), busy, vt[i].bsy);
            chk($sformatf("v%0d.seed_update", i), seed_update, vt[i].upd);
            chk($sformatf("v%0d.seed_ok", i), seed_ok, vt[i].ok);
            chk($sformatf("v%0d.col0", i), col0, vt[i].col);
            chk($sformatf("v%0d.rrow0", i), rrow0, vt[i].row);
        end
        load_start = 1'b0;
        s_valid    = 1'b0;

        // stalled stream, then hold in COMMIT
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send(64'hAAAAAAAAAAAAAAAA);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("gap%0d.s_ready", i), s_ready, 1'b1);
        end
        send(64'h5555555555555555);
        send(64'h0123456789ABCDEF);
        send(64'hFEDCBA9876543210);
        send(64'h1);
        hold = 1'b1;
        send(64'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("hold%0d", i), EC1, ER1);
            chk($sformatf("hold%0d.busy", i), busy, 1'b1);
            chk($sformatf("hold%0d.seed_update", i), seed_update, 1'b0);
        end
        hold = 1'b0;
        tick();
        pc = {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555};
        pr = rowx(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h1, 64'h2);
        chk_out("stall", pc, pr);
        chk("stall.seed_update", seed_update, 1'b1);
        chk("stall.busy", busy, 1'b0);
        tick();
        chk("stall.upd_once", seed_update, 1'b0);

        // abort after 3 of 6 words with a word presented
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send(64'h7777777777777777);
        send(64'h8888888888888888);
        send(64'h9999999999999999);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 64'hDEADBEEFDEADBEEF;
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("abort.busy", busy, 1'b0);
        chk("abort.s_ready", s_ready, 1'b0);
        chk("abort.seed_ok", seed_ok, 1'b1);
        chk_out("abort", pc, pr);
        tick();
        chk("abort.seed_update", seed_update, 1'b0);

        // abort while waiting in COMMIT
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) send(64'hCC00 + 64'(i));
        hold = 1'b1;
        send(64'hCC05);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        hold  = 1'b0;
        tick();
        chk("abortc.busy", busy, 1'b0);
        chk("abortc.seed_update", seed_update, 1'b0);
        chk_out("abortc", pc, pr);

        // fresh load, with load_start raised during LOAD_ROW
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send(64'h0F0F0F0F0F0F0F0F);
        send(64'hF0F0F0F0F0F0F0F0);
        send(64'h1);
        load_start = 1'b1;
        send(64'h3);
        load_start = 1'b0;
        send(64'h5);
        send(64'hFFFFFFFFFFFFFFFF);
        chk("lsrow.commit_state", s_ready, 1'b0);
        tick();
        chk_out("lsrow", {64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0}, rowx(64'h1, 64'h3, 64'h5, 64'hFFFFFFFFFFFFFFFF));
        chk("lsrow.seed_update", seed_update, 1'b1);
        chk("lsrow.busy", busy, 1'b0);

        // asynchronous reset between edges, mid-load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send(64'h4444444444444444);
        chk("arst.pre_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.busy", busy, 1'b0);
        chk("arst.s_ready", s_ready, 1'b0);
        chk("arst.seed_ok", seed_ok, 1'b0);
        chk_out("arst", '0, '0);
        #2;
        rst = 1'b0;
        tick();
        chk("arst.idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
